// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-side constants and the redirect state type
//
// Purpose : common definitions used by the fetch PC redirect controller.
// Contents: RESET_PC_DEFAULT (boot fetch address), PC_INC (sequential step),
//           redirect_state_t (IDLE / PEND).
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic {
        IDLE = 1'b0,   // no redirect outstanding
        PEND = 1'b1    // taken target latched, waiting for IF to advance
    } redirect_state_t;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC register with delayed-branch redirect and likely-branch annul
//
// Purpose : owns the fetch PC. Applies a taken ID-stage branch after the
//           delay slot, holds a resolved redirect across IF stalls, and
//           nullifies the delay slot of a not-taken branch-likely.
// Ports   :
//   clk, rst          clock, synchronous active-high reset
//   id_valid_i        ID holds a valid, non-annulled instruction
//   id_is_branch_i    ID instruction is a conditional branch
//   id_is_likely_i    ID branch is a likely variant
//   id_taken_i        branch condition from the ID comparator
//   id_pc_i           PC of the ID instruction
//   id_target_i       precomputed branch target
//   if_stall_i        IF/ID cannot advance this cycle
//   flush_i           exception / ERET flush
//   flush_pc_i        flush redirect address
//   pc_o              registered fetch PC
//   if_annul_o        registered: instruction entering ID is a nullified slot
//   id_link_addr_o    id_pc_i + 8, combinational
module pc_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic        id_is_branch_i,
    input  logic        id_is_likely_i,
    input  logic        id_taken_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_target_i,
    input  logic        if_stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] pc_o,
    output logic        if_annul_o,
    output logic [31:0] id_link_addr_o
);

    redirect_state_t state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     target_q, target_d;
    logic            annul_q, annul_d;
    // Annul request captured while stalled, issued on the first free cycle.
    logic            annul_pend_q, annul_pend_d;

    logic branch_ev;
    logic taken_ev;
    logic annul_cond;

    assign branch_ev  = id_valid_i & id_is_branch_i;
    assign taken_ev   = branch_ev & id_taken_i;
    assign annul_cond = branch_ev & id_is_likely_i & ~id_taken_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            target_q     <= '0;
            annul_q      <= 1'b0;
            annul_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            annul_q      <= annul_d;
            annul_pend_q <= annul_pend_d;
        end
    end

    // Next-state / next-PC selection: flush > stall > pending > branch > sequential
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        annul_d      = 1'b0;
        annul_pend_d = annul_pend_q;

        if (flush_i) begin
            // Flush overrides everything; any pending redirect is discarded.
            pc_d         = flush_pc_i;
            state_d      = IDLE;
            target_d     = '0;
            annul_pend_d = 1'b0;
        end else if (if_stall_i) begin
            // PC holds. In PEND the frozen ID branch is not sampled again.
            if (state_q == IDLE) begin
                if (taken_ev) begin
                    target_d = id_target_i;
                    state_d  = PEND;
                end
                if (annul_cond) begin
                    annul_pend_d = 1'b1;
                end
            end
        end else if (state_q == PEND) begin
            pc_d         = target_q;
            state_d      = IDLE;
            annul_d      = annul_pend_q;
            annul_pend_d = 1'b0;
        end else begin
            if (taken_ev) begin
                pc_d = id_target_i;
            end else begin
                pc_d = pc_q + PC_INC;
            end
            annul_d      = annul_cond | annul_pend_q;
            annul_pend_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        pc_o           = pc_q;
        if_annul_o     = annul_q;
        id_link_addr_o = id_pc_i + 32'd8;
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - scoreboard bench for the fetch PC redirect controller
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic        id_is_branch_i;
    logic        id_is_likely_i;
    logic        id_taken_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_target_i;
    logic        if_stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] pc_o;
    logic        if_annul_o;
    logic [31:0] id_link_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic        annul;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_is_branch_i (id_is_branch_i),
        .id_is_likely_i (id_is_likely_i),
        .id_taken_i     (id_taken_i),
        .id_pc_i        (id_pc_i),
        .id_target_i    (id_target_i),
        .if_stall_i     (if_stall_i),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .pc_o           (pc_o),
        .if_annul_o     (if_annul_o),
        .id_link_addr_o (id_link_addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare registered outputs just after each active edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, "_pc"}, pc_o, e.pc);
            chk({e.tag, "_annul"}, {31'd0, if_annul_o}, {31'd0, e.annul});
        end
    end

    // Drive one cycle of stimulus on the falling edge and push the outputs
    // expected after the following rising edge.
    task automatic drive(input string tag, input logic r,
                         input logic v, input logic br, input logic lk, input logic tk,
                         input logic [31:0] ipc, input logic [31:0] tgt,
                         input logic st, input logic fl, input logic [31:0] fpc,
                         input logic [31:0] epc, input logic ean);
        exp_t e;
        @(negedge clk);
        rst            = r;
        id_valid_i     = v;
        id_is_branch_i = br;
        id_is_likely_i = lk;
        id_taken_i     = tk;
        id_pc_i        = ipc;
        id_target_i    = tgt;
        if_stall_i     = st;
        flush_i        = fl;
        flush_pc_i     = fpc;
        #1;
        if (v && br) chk({tag, "_link"}, id_link_addr_o, ipc + 32'd8);
        e.pc    = epc;
        e.annul = ean;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string tag, input logic [31:0] epc);
        drive(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, epc, 1'b0);
    endtask

    task automatic do_flush(input string tag, input logic [31:0] fpc);
        drive(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, fpc, fpc, 1'b0);
    endtask

    localparam logic [31:0] BR_PC  = 32'hBFC0_0010;
    localparam logic [31:0] BR_TGT = 32'hBFC0_0100;

    initial begin
        rst = 1'b1; id_valid_i = 0; id_is_branch_i = 0; id_is_likely_i = 0; id_taken_i = 0;
        id_pc_i = 0; id_target_i = 0; if_stall_i = 0; flush_i = 0; flush_pc_i = 0;

        // Reset and free running
        drive("reset", 1'b1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'hBFC0_0000, 1'b0);
        idle("seq1", 32'hBFC0_0004);
        idle("seq2", 32'hBFC0_0008);
        idle("seq3", 32'hBFC0_000C);
        idle("seq4", 32'hBFC0_0010);
        idle("seq5", 32'hBFC0_0014);

        // BEQ taken, unstalled
        drive("beq_taken", 0, 1, 1, 0, 1, BR_PC, BR_TGT, 0, 0, 32'h0, BR_TGT, 1'b0);
        idle("after_beq", 32'hBFC0_0104);

        // Taken branch stalled for three cycles
        do_flush("fl_0014a", 32'hBFC0_0014);
        for (int i = 0; i < 3; i++)
            drive("stall_hold", 0, 1, 1, 0, 1, BR_PC, BR_TGT, 1, 0, 32'h0, 32'hBFC0_0014, 1'b0);
        drive("stall_release", 0, 1, 1, 0, 1, BR_PC, BR_TGT, 0, 0, 32'h0, BR_TGT, 1'b0);
        idle("after_release", 32'hBFC0_0104);

        // BNEL not taken: delay slot annulled for one cycle
        do_flush("fl_0014b", 32'hBFC0_0014);
        drive("bnel_nt", 0, 1, 1, 1, 0, BR_PC, BR_TGT, 0, 0, 32'h0, 32'hBFC0_0018, 1'b1);
        idle("bnel_after", 32'hBFC0_001C);

        // BNE not taken: no annul
        drive("bne_nt", 0, 1, 1, 0, 0, 32'hBFC0_0018, BR_TGT, 0, 0, 32'h0, 32'hBFC0_0020, 1'b0);

        // Likely not-taken while stalled: annul issued on release
        drive("bnel_st1", 0, 1, 1, 1, 0, 32'hBFC0_001C, BR_TGT, 1, 0, 32'h0, 32'hBFC0_0020, 1'b0);
        drive("bnel_st2", 0, 1, 1, 1, 0, 32'hBFC0_001C, BR_TGT, 1, 0, 32'h0, 32'hBFC0_0020, 1'b0);
        drive("bnel_rel", 0, 1, 1, 1, 0, 32'hBFC0_001C, BR_TGT, 0, 0, 32'h0, 32'hBFC0_0024, 1'b1);
        idle("bnel_rel_after", 32'hBFC0_0028);

        // Flush while pending and stalled discards the target
        drive("pend_enter", 0, 1, 1, 0, 1, 32'hBFC0_0024, BR_TGT, 1, 0, 32'h0, 32'hBFC0_0028, 1'b0);
        drive("pend_flush", 0, 1, 1, 0, 1, 32'hBFC0_0024, BR_TGT, 1, 1, 32'hBFC0_0380, 32'hBFC0_0380, 1'b0);
        drive("post_flush_st", 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'hBFC0_0380, 1'b0);
        idle("post_flush_rel", 32'hBFC0_0384);

        // PC wrap
        do_flush("fl_wrap", 32'hFFFF_FFFC);
        idle("wrap0", 32'h0000_0000);
        idle("wrap1", 32'h0000_0004);

        // Reset during PEND
        drive("pend2", 0, 1, 1, 0, 1, 32'h0000_0000, BR_TGT, 1, 0, 32'h0, 32'h0000_0004, 1'b0);
        drive("rst_pend", 1, 1, 1, 0, 1, 32'h0000_0000, BR_TGT, 1, 0, 32'h0, 32'hBFC0_0000, 1'b0);
        idle("rst_pend_after", 32'hBFC0_0004);

        // Reset beats a simultaneous flush
        drive("rst_flush", 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'hBFC0_0380, 32'hBFC0_0000, 1'b0);
        idle("rst_flush_after", 32'hBFC0_0004);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
